riscv_fetch_q: RTL and testbench
================================

Name: riscv_fetch_q

Overview:
Parametrised successor of the single-entry fetch stage. It keeps up to MAX_OUTSTANDING pipelined I-cache reads in flight and buffers returned instructions in a FIFO_DEPTH-entry prefetch queue. It sits between the I-cache port and decode. Branches flush the queue and squash in-flight responses without stalling the cache port.

Parameters:
FIFO_DEPTH, 4, prefetch queue entries; power of 2, >=2
MAX_OUTSTANDING, 2, max accepted-but-unreturned I-cache reads; 1..FIFO_DEPTH
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous active-low reset
fetch_branch_i  in  1  redirect request, single-cycle pulse
fetch_branch_pc_i  in  32  redirect target, word aligned
fetch_accept_i  in  1  decode takes head instruction this cycle
fetch_invalidate_i  in  1  request I-cache flush
icache_accept_i  in  1  cache accepts icache_rd_o this cycle
icache_valid_i  in  1  in-order read response valid
icache_error_i  in  1  response carries bus/access fault
icache_inst_i  in  32  response instruction word
fetch_valid_o  out  1  head instruction valid
fetch_instr_o  out  32  head instruction; INST_FAULT on fault
fetch_pc_o  out  32  PC of head instruction
fetch_fault_o  out  1  head entry came from a faulted response
icache_rd_o  out  1  read request
icache_pc_o  out  32  read address
icache_flush_o  out  1  cache flush request

Behaviour:
- Reset values: fetch_valid_o=0, fetch_fault_o=0, icache_flush_o=0; fetch_pc_q=RESET_PC; outstanding count, drop count and queue empty. icache_rd_o may assert in the first cycle after reset release.
- Credit: icache_rd_o = (outstanding < MAX_OUTSTANDING) && (outstanding + queue_count < FIFO_DEPTH). Every accepted read therefore has a guaranteed queue slot, so responses are never back-pressured.
- Address: icache_pc_o = fetch_branch_i ? fetch_branch_pc_i : fetch_pc_q. When icache_rd_o && icache_accept_i, fetch_pc_q <= icache_pc_o + 4 (mod 2^32, wraps silently).
- Branch without an accepted read in the same cycle: fetch_pc_q <= fetch_branch_pc_i.
- Response PC: rsp_pc_q tracks the PC of the oldest in-flight read.
  - Increments by 4 on each kept response.
  - On a branch, rsp_pc_q <= fetch_branch_pc_i.
- Branch flush, same cycle:
  - Queue is emptied; fetch_valid_o is 0 from the next cycle.
  - drop_q <= outstanding after this cycle's response, excluding any read accepted this cycle.
  - A read accepted in the branch cycle targets fetch_branch_pc_i and is kept.
- Response handling:
  - If drop_q > 0, the response is discarded and drop_q is decremented.
  - Otherwise the queue is written with {fault, pc, instr}.
  - outstanding: +1 on accepted read, -1 on response; both together leaves it unchanged.
- Fault: icache_error_i stores instr=INST_FAULT with fault=1. Fetch continues sequentially.
- Output: queue head is shown when the queue is non-empty. A pop happens on fetch_valid_o && fetch_accept_i. The head holds stable while fetch_accept_i is low.
- Queue full and pop in the same cycle: write and pop are allowed together; count is unchanged.
- Invalidate: fetch_invalidate_i sets flush_pend_q. icache_flush_o = fetch_invalidate_i | flush_pend_q. flush_pend_q clears on icache_accept_i while icache_flush_o is high.
- Reset mid-operation discards all in-flight state. Late responses after reset are not tolerated; the cache must be reset together with this block.

Optional Feature:
RISCV_FETCH_BYPASS_EN
- Defined: when the queue is empty and a kept response arrives, it drives fetch_* combinationally in the same cycle. If fetch_accept_i is high, it is consumed without being written. Latency is response-to-decode in 0 cycles.
- Undefined: every response goes through the queue, giving 1 cycle of latency. No combinational path exists from icache_* to fetch_*.

Decomposition:
- Package riscv_fetch_pkg:
  - INST_FAULT constant
  - queue-entry typedef {fault, pc[31:0], instr[31:0]} (65 bits)
  - count-width helper ($clog2-based)
- Sub-module riscv_fetch_fifo:
  - synchronous FIFO with parameters WIDTH and DEPTH
  - ports push/pop/flush/full/empty/count
  - async active-low reset on clk_i/rst_i

Test Plan:
- Reset release, icache_accept_i=1, 1-cycle response latency, fetch_accept_i=1 -> reads at 0x0,0x4,0x8,0xC back-to-back; fetch_pc_o follows 0x0,0x4,... with no bubbles after fill.
- fetch_accept_i=0 for 10 cycles -> queue fills with exactly FIFO_DEPTH=4 entries; icache_rd_o deasserts once outstanding+count=4; the head stays at 0x0 throughout.
- MAX_OUTSTANDING=2 with 2 reads outstanding, branch to 0x100 -> both old responses dropped; first fetch_pc_o after the branch is 0x100, and no 0x8 or 0xC instruction is delivered.
- Branch to 0x200 in the same cycle as an accepted read and a returning response -> that read's address is 0x200; the response is dropped; next delivered PC is 0x200.
- icache_error_i on the response for 0x40 -> fetch_instr_o=INST_FAULT and fetch_fault_o=1 at PC 0x40; next entry is PC 0x44, not faulted.
- fetch_invalidate_i pulse while icache_accept_i=0 for 3 cycles -> icache_flush_o high for 4 cycles, then low; assertion of rst_i mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the pipelined fetch queue.
package riscv_fetch_pkg;

  localparam logic [31:0] INST_FAULT = 32'h0000_0000;

  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Bits needed to hold a count in 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Small synchronous FIFO with flush; head is read combinationally.
module riscv_fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int CW   = cnt_w(DEPTH),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem[rd_ptr_q];

  // A full queue still takes a write when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i) && !flush_i;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/riscv_fetch_q.sv
// Fetch stage with pipelined I-cache reads and a prefetch queue.
// Optional RISCV_FETCH_BYPASS_EN: zero-latency response-to-decode when the queue is empty.
module riscv_fetch_q
  import riscv_fetch_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_branch_i,
  input  logic [31:0] fetch_branch_pc_i,
  input  logic        fetch_accept_i,
  input  logic        fetch_invalidate_i,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic        icache_error_i,
  input  logic [31:0] icache_inst_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic        fetch_fault_o,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  output logic        icache_flush_o
);

  localparam int CW = cnt_w(FIFO_DEPTH);

  logic [CW-1:0] out_q, out_d, drop_q, drop_d, q_count;
  logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic          flush_pend_q, flush_pend_d;
  logic          q_full, q_empty, q_push, q_pop, rd_acc, rsp_keep;
  logic [CW:0]   credit_sum;
  fetch_entry_t  q_head, rsp_entry, head;

  // Reserving a queue slot per accepted read means responses never stall.
  assign credit_sum  = {1'b0, out_q} + {1'b0, q_count};
  assign icache_rd_o = (out_q < CW'(MAX_OUTSTANDING)) && (credit_sum < (CW+1)'(FIFO_DEPTH));
  assign icache_pc_o = fetch_branch_i ? fetch_branch_pc_i : fetch_pc_q;
  assign rd_acc      = icache_rd_o && icache_accept_i;

  // Responses in a branch cycle belong to the old path and are squashed.
  assign rsp_keep        = icache_valid_i && (drop_q == '0) && !fetch_branch_i;
  assign rsp_entry.fault = icache_error_i;
  assign rsp_entry.pc    = rsp_pc_q;
  assign rsp_entry.instr = icache_error_i ? INST_FAULT : icache_inst_i;

  assign q_pop = !q_empty && fetch_accept_i;

`ifdef RISCV_FETCH_BYPASS_EN
  logic byp;
  assign byp           = q_empty && rsp_keep;
  assign fetch_valid_o = !q_empty || byp;
  assign head          = byp ? rsp_entry : q_head;
  assign q_push        = rsp_keep && !(byp && fetch_accept_i) && (!q_full || q_pop);
`else
  assign fetch_valid_o = !q_empty;
  assign head          = q_head;
  assign q_push        = rsp_keep && (!q_full || q_pop);
`endif

  assign fetch_pc_o     = head.pc;
  assign fetch_instr_o  = head.instr;
  assign fetch_fault_o  = fetch_valid_o && head.fault;
  assign icache_flush_o = fetch_invalidate_i || flush_pend_q;

  riscv_fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (q_push),
    .data_i  (rsp_entry),
    .pop_i   (q_pop),
    .flush_i (fetch_branch_i),
    .data_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    rsp_pc_d     = rsp_pc_q;
    drop_d       = drop_q;
    flush_pend_d = flush_pend_q;
    out_d        = out_q + CW'(rd_acc) - CW'(icache_valid_i);

    if (rd_acc)              fetch_pc_d = icache_pc_o + 32'd4;
    else if (fetch_branch_i) fetch_pc_d = fetch_branch_pc_i;

    if (fetch_branch_i) rsp_pc_d = fetch_branch_pc_i;
    else if (rsp_keep)  rsp_pc_d = rsp_pc_q + 32'd4;

    // Everything still in flight after this cycle is stale, except a read issued now.
    if (fetch_branch_i)                        drop_d = out_q - CW'(icache_valid_i);
    else if (icache_valid_i && drop_q != '0)   drop_d = drop_q - 1'b1;

    if (icache_flush_o && icache_accept_i) flush_pend_d = 1'b0;
    else if (fetch_invalidate_i)           flush_pend_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_q        <= '0;
      drop_q       <= '0;
      fetch_pc_q   <= RESET_PC;
      rsp_pc_q     <= RESET_PC;
      flush_pend_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      drop_q       <= drop_d;
      fetch_pc_q   <= fetch_pc_d;
      rsp_pc_q     <= rsp_pc_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_riscv_fetch_q.sv
// Scoreboard bench for riscv_fetch_q: cache model, path-epoch reference model, decoupled monitor.
module tb_riscv_fetch_q;
  import riscv_fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic        fetch_branch_i = 0, fetch_accept_i = 0, fetch_invalidate_i = 0;
  logic [31:0] fetch_branch_pc_i = '0, icache_inst_i = '0;
  logic        icache_accept_i = 0, icache_valid_i = 0, icache_error_i = 0;
  logic        fetch_valid_o, fetch_fault_o, icache_rd_o, icache_flush_o;
  logic [31:0] fetch_instr_o, fetch_pc_o, icache_pc_o;

  riscv_fetch_q #(.FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fetch_branch_i(fetch_branch_i), .fetch_branch_pc_i(fetch_branch_pc_i),
    .fetch_accept_i(fetch_accept_i), .fetch_invalidate_i(fetch_invalidate_i),
    .icache_accept_i(icache_accept_i), .icache_valid_i(icache_valid_i),
    .icache_error_i(icache_error_i), .icache_inst_i(icache_inst_i),
    .fetch_valid_o(fetch_valid_o), .fetch_instr_o(fetch_instr_o),
    .fetch_pc_o(fetch_pc_o), .fetch_fault_o(fetch_fault_o),
    .icache_rd_o(icache_rd_o), .icache_pc_o(icache_pc_o),
    .icache_flush_o(icache_flush_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] pc; int epoch; } rd_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; } exp_t;

  rd_t         pend[$];   // reads accepted by the cache model, oldest first
  exp_t        sb[$];     // instructions decode should still see, in order
  int          epoch = 0;
  logic [31:0] next_pc = RPC;
  bit          fl_pend = 0;
  bit          mon_en = 0;
  int          checks = 0, errors = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, then account for this cycle's handshakes.
  task automatic cycle(input bit br, input logic [31:0] bpc, input bit facc, input bit inv,
                       input bit iacc, input bit rsp_ok, input bit err);
    rd_t r;
    bit  exp_fl;
    @(posedge clk_i); #1;
    fetch_branch_i = br; fetch_branch_pc_i = bpc; fetch_accept_i = facc;
    fetch_invalidate_i = inv; icache_accept_i = iacc;
    if (rsp_ok && pend.size() > 0) begin
      icache_valid_i = 1; icache_error_i = err; icache_inst_i = mem(pend[0].pc);
    end else begin
      icache_valid_i = 0; icache_error_i = 0; icache_inst_i = $urandom;
    end
    #2;
    chk("rd_credit", 32'(icache_rd_o), 32'((pend.size() < MAXO) && (pend.size() + sb.size() < DEPTH)));
    exp_fl = inv || fl_pend;
    chk("flush_o", 32'(icache_flush_o), 32'(exp_fl));
    if (exp_fl && iacc) fl_pend = 0;
    else if (inv)       fl_pend = 1;
    if (icache_valid_i) begin
      r = pend.pop_front();
      if (r.epoch == epoch && !br) begin
        sb.push_back('{pc: next_pc, instr: (err ? INST_FAULT : mem(next_pc)), fault: err});
        next_pc += 32'd4;
      end
    end
    if (br) begin
      sb.delete();
      epoch++;
      next_pc = bpc;
    end
    if (icache_rd_o && iacc) pend.push_back('{pc: icache_pc_o, epoch: epoch});
  endtask

  task automatic drain();
    int n = 0;
    while ((pend.size() > 0 || sb.size() > 0) && n < 200) begin
      cycle(0, '0, 1, 0, 0, 1, 0);
      n++;
    end
    checks++;
    if (pend.size() > 0 || sb.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: pending %0d queued %0d", pend.size(), sb.size());
    end
  endtask

  // Monitor: compares whatever decode consumes against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (mon_en && fetch_valid_o && !fetch_branch_i) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got pc %h expected nothing", fetch_pc_o);
        end else if (fetch_accept_i) begin
          e = sb.pop_front();
          chk("out_pc", fetch_pc_o, e.pc);
          chk("out_instr", fetch_instr_o, e.instr);
          chk("out_fault", 32'(fetch_fault_o), 32'(e.fault));
        end else begin
          chk("head_hold_pc", fetch_pc_o, sb[0].pc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bpc;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", 32'(fetch_valid_o), 0);
    chk("rst_fault", 32'(fetch_fault_o), 0);
    chk("rst_flush", 32'(icache_flush_o), 0);
    rst_i = 1; #1;
    chk("rst_rd", 32'(icache_rd_o), 1);
    chk("rst_pc", icache_pc_o, RPC);
    mon_en = 1;

    // Streaming with 1-cycle cache latency: no bubbles once filled.
    for (int i = 0; i < 12; i++) begin
      cycle(0, '0, 1, 0, 1, 1, 0);
      if (i >= 3) chk("stream_valid", 32'(fetch_valid_o), 1);
    end
    // Decode stalls: queue fills and reads stop.
    for (int i = 0; i < 10; i++) cycle(0, '0, 0, 0, 1, 1, 0);
    chk("full_rd", 32'(icache_rd_o), 0);
    chk("full_valid", 32'(fetch_valid_o), 1);
    drain();

    // Branch with two reads in flight.
    cycle(0, '0, 1, 0, 1, 0, 0);
    cycle(0, '0, 1, 0, 1, 0, 0);
    cycle(1, 32'h100, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, '0, 1, 0, 1, 1, 0);
    drain();

    // Branch coinciding with an accepted read and a returning response.
    cycle(0, '0, 1, 0, 1, 0, 0);
    cycle(1, 32'h200, 1, 0, 1, 1, 0);
    chk("br_rd_addr", icache_pc_o, 32'h200);
    for (int i = 0; i < 6; i++) cycle(0, '0, 1, 0, 1, 1, 0);
    drain();

    // Faulted response at 0x40, then a clean one.
    cycle(1, 32'h40, 1, 0, 0, 0, 0);
    cycle(0, '0, 1, 0, 1, 0, 0);
    cycle(0, '0, 1, 0, 1, 1, 1);
    cycle(0, '0, 1, 0, 0, 1, 0);
    drain();

    // Invalidate while the cache holds off, then accepts.
    cycle(0, '0, 1, 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0, 0);
    cycle(0, '0, 1, 0, 1, 0, 0);
    cycle(0, '0, 1, 0, 0, 1, 0);
    drain();

    // Randomized traffic including wrap-around targets.
    for (int i = 0; i < 3000; i++) begin
      bpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                       : ($urandom & 32'h0000_FFFC);
      cycle($urandom_range(0, 15) == 0, bpc, $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
    end
    drain();

    // Reset mid-burst.
    for (int i = 0; i < 4; i++) cycle(0, '0, 0, 0, 1, 1, 0);
    @(posedge clk_i); #3;
    mon_en = 0;
    fetch_invalidate_i = 0;
    rst_i = 0; #1;
    chk("midrst_valid", 32'(fetch_valid_o), 0);
    chk("midrst_fault", 32'(fetch_fault_o), 0);
    chk("midrst_flush", 32'(icache_flush_o), 0);
    pend.delete(); sb.delete(); fl_pend = 0;
    fetch_branch_i = 0; fetch_accept_i = 0; icache_accept_i = 0; icache_valid_i = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1; #1;
    chk("midrst_rd", 32'(icache_rd_o), 1);
    chk("midrst_pc", icache_pc_o, RPC);
    epoch++; next_pc = RPC; mon_en = 1;
    for (int i = 0; i < 8; i++) cycle(0, '0, 1, 0, 1, 1, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
